// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: divides the system clock into a pixel enable and
// produces registered hsync/vsync/enable/column/row plus tick and start strobes.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CLK_DIV  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       hsync,
  output logic       vsync,
  output logic       enable,
  output logic [9:0] column,
  output logic [9:0] row,
  output logic       pixel_tick,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       h_cnt_q, h_cnt_d;
  logic [9:0]       v_cnt_q, v_cnt_d;
  logic [9:0]       column_q, column_d;
  logic [9:0]       row_q, row_d;
  logic             enable_q, enable_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             pixel_tick_q;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic             tick_s;

  assign tick_s = (div_cnt_q == DIV_LAST);

  // Next-state: advance divider and raster counters, derive outputs from the new counts
  always_comb begin
    div_cnt_d     = div_cnt_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    column_d      = column_q;
    row_d         = row_q;
    enable_d      = enable_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (tick_s) begin
      div_cnt_d = DIV_ZERO;
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = 10'd0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d = 10'd0;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
      end
      column_d      = h_cnt_d;
      row_d         = v_cnt_d;
      enable_d      = (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
      hsync_d       = ((h_cnt_d >= HS_START) && (h_cnt_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vsync_d       = ((v_cnt_d >= VS_START) && (v_cnt_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
      line_start_d  = (h_cnt_d == 10'd0);
      frame_start_d = (h_cnt_d == 10'd0) && (v_cnt_d == 10'd0);
    end else begin
      div_cnt_d = div_cnt_q + DIV_ONE;
    end
  end

  // Counter and output registers; reset parks counters on the last position so the first tick wraps to 0,0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q     <= DIV_ZERO;
      h_cnt_q       <= H_LAST;
      v_cnt_q       <= V_LAST;
      column_q      <= 10'd0;
      row_q         <= 10'd0;
      enable_q      <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      pixel_tick_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      column_q      <= column_d;
      row_q         <= row_d;
      enable_q      <= enable_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      pixel_tick_q  <= tick_s;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign enable      = enable_q;
  assign column      = column_q;
  assign row         = row_q;
  assign pixel_tick  = pixel_tick_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: two reduced-geometry instances (CLK_DIV=2/active-low
// and CLK_DIV=1/active-high) checked against a pixel-index reference model under random resets.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  typedef struct packed {
    logic [9:0] col;
    logic [9:0] row;
    logic       en;
    logic       hs;
    logic       vs;
    logic       pt;
    logic       ls;
    logic       fs;
  } pos_t;

  logic       clk;
  logic       rst_n;
  logic       hsync[2];
  logic       vsync[2];
  logic       enable[2];
  logic [9:0] column[2];
  logic [9:0] row[2];
  logic       pixel_tick[2];
  logic       line_start[2];
  logic       frame_start[2];

  int   checks;
  int   failures;
  pos_t exp_q[2][$];
  bit   in_reset[2];

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .CLK_DIV(2)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .hsync(hsync[0]), .vsync(vsync[0]), .enable(enable[0]),
    .column(column[0]), .row(row[0]), .pixel_tick(pixel_tick[0]),
    .line_start(line_start[0]), .frame_start(frame_start[0])
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b1), .CLK_DIV(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .hsync(hsync[1]), .vsync(vsync[1]), .enable(enable[1]),
    .column(column[1]), .row(row[1]), .pixel_tick(pixel_tick[1]),
    .line_start(line_start[1]), .frame_start(frame_start[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int div_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic bit pol_of(input int k);
    return (k == 0) ? 1'b0 : 1'b1;
  endfunction

  // Expected outputs for the p-th pixel presented after reset release
  function automatic pos_t ref_pos(input int k, input int p);
    pos_t e;
    int   c;
    int   r;
    bit   pol;
    pol  = pol_of(k);
    c    = p % HT;
    r    = (p / HT) % VT;
    e.col = 10'(c);
    e.row = 10'(r);
    e.en  = (c < HA) && (r < VA);
    e.hs  = (c >= HA + HF && c < HA + HF + HS) ? pol : ~pol;
    e.vs  = (r >= VA + VF && r < VA + VF + VS) ? pol : ~pol;
    e.pt  = 1'b1;
    e.ls  = (c == 0);
    e.fs  = (c == 0) && (r == 0);
    return e;
  endfunction

  function automatic pos_t reset_pos(input int k);
    pos_t e;
    e     = '0;
    e.hs  = ~pol_of(k);
    e.vs  = ~pol_of(k);
    return e;
  endfunction

  function automatic pos_t sample(input int k);
    pos_t a;
    a.col = column[k];
    a.row = row[k];
    a.en  = enable[k];
    a.hs  = hsync[k];
    a.vs  = vsync[k];
    a.pt  = pixel_tick[k];
    a.ls  = line_start[k];
    a.fs  = frame_start[k];
    return a;
  endfunction

  task automatic cmp_pos(input int k, input string nm, input pos_t act, input pos_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t actual col=%0d row=%0d en=%b hs=%b vs=%b pt=%b ls=%b fs=%b required col=%0d row=%0d en=%b hs=%b vs=%b pt=%b ls=%b fs=%b",
               nm, k, $time, act.col, act.row, act.en, act.hs, act.vs, act.pt, act.ls, act.fs,
               exp.col, exp.row, exp.en, exp.hs, exp.vs, exp.pt, exp.ls, exp.fs);
    end
  endtask

  task automatic cmp_int(input int k, input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t actual=%0d required=%0d", nm, k, $time, act, exp);
    end
  endtask

  // Reference model: counts edges since release and pushes one expected pixel per CLK_DIV edges
  initial begin
    int edges[2];
    int pix[2];
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          in_reset[k] = 1'b1;
          edges[k]    = 0;
          pix[k]      = 0;
          exp_q[k].delete();
        end else begin
          in_reset[k] = 1'b0;
          edges[k]++;
          if (edges[k] % div_of(k) == 0) begin
            exp_q[k].push_back(ref_pos(k, pix[k]));
            pix[k]++;
          end
        end
      end
    end
  end

  // Monitor: pops on each DUT pixel_tick, checks hold between ticks and frame statistics
  initial begin
    pos_t held[2];
    pos_t act;
    pos_t hexp;
    int   cyc;
    int   last_fs[2];
    bit   have_fs[2];
    int   tick_cnt[2];
    int   en_cnt[2];
    cyc = 0;
    for (int k = 0; k < 2; k++) begin
      held[k]    = reset_pos(k);
      have_fs[k] = 1'b0;
      last_fs[k] = 0;
      tick_cnt[k] = 0;
      en_cnt[k]  = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        act = sample(k);
        if (in_reset[k]) begin
          cmp_pos(k, "reset_state", act, reset_pos(k));
          held[k]    = reset_pos(k);
          have_fs[k] = 1'b0;
        end else if (act.pt) begin
          if (exp_q[k].size() == 0) begin
            cmp_int(k, "unexpected_tick", 1, 0);
          end else begin
            cmp_pos(k, "pixel", act, exp_q[k].pop_front());
          end
          if (act.fs) begin
            if (have_fs[k]) begin
              cmp_int(k, "frame_period_clks", cyc - last_fs[k], HT * VT * div_of(k));
              cmp_int(k, "ticks_per_frame", tick_cnt[k], HT * VT);
              cmp_int(k, "enable_ticks_per_frame", en_cnt[k], HA * VA);
            end
            have_fs[k]  = 1'b1;
            last_fs[k]  = cyc;
            tick_cnt[k] = 0;
            en_cnt[k]   = 0;
          end
          tick_cnt[k]++;
          if (act.en) en_cnt[k]++;
          held[k] = act;
        end else begin
          cmp_int(k, "missing_tick", exp_q[k].size(), 0);
          hexp    = held[k];
          hexp.pt = 1'b0;
          hexp.ls = 1'b0;
          hexp.fs = 1'b0;
          cmp_pos(k, "hold", act, hexp);
        end
      end
    end
  end

  // Stimulus: long initial run, random reset pulses, then a targeted mid-frame reset
  initial begin
    bit hit;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * HT * VT * 2 + 10) @(negedge clk);
    for (int s = 0; s < 6; s++) begin
      rst_n = 1'b0;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      rst_n = 1'b1;
      repeat ($urandom_range(3, 900)) @(negedge clk);
    end
    hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge clk);
      hit = (row[0] == 10'd5) && (column[0] == 10'd10);
    end
    cmp_int(0, "reach_mid_frame", int'(hit), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * HT * VT * 2 + 10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
